// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helper for the key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key: synchroniser, stability FSM, auto-repeat counter, registered outputs.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY = 200,
    parameter int unsigned REPEAT_RATE  = 40,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int unsigned CNT_W      = width_for(STABLE_TICKS - 1);
    localparam int unsigned RPT_W      = width_for(REPEAT_DELAY);
    localparam int unsigned RELOAD_VAL = (REPEAT_RATE >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_RATE;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RELOAD_VAL);

    logic [1:0]       sync_q;
    logic             s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
    logic             press_d, release_d, repeat_d;

    assign s       = sync_q[1];
    assign rpt_inc = (&rpt_q) ? rpt_q : rpt_q + RPT_W'(1);

    // Synchroniser and state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b00;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rpt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in ^ ACTIVE_LOW};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            key_level   <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            key_press   <= press_d;
            key_release <= release_d;
            key_repeat  <= repeat_d;
        end
    end

    // Next state; everything holds except on a sample tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else if ((REPEAT_DELAY != 0) && (rpt_inc == RPT_FIRE)) begin
                        repeat_d = 1'b1;
                        rpt_d    = RPT_RELOAD;
                    end else begin
                        rpt_d = rpt_inc;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// N-key debouncer: sample tick from a clk_div bit rising edge, one channel per key.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned TICK_BIT     = 17,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY = 200,
    parameter int unsigned REPEAT_RATE  = 40,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  clk_div,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_repeat
);

    logic tick_prev;
    logic tick;
    logic unused_div;

    // Only the rising edge counts, so the wrap-induced fall never ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_prev <= 1'b0;
        else     tick_prev <= clk_div[TICK_BIT];
    end

    assign tick       = clk_div[TICK_BIT] & ~tick_prev;
    assign unused_div = ^clk_div;

    for (genvar i = 0; i < N; i++) begin : gen_ch
        key_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: per-tick directed table plus randomized run against a run-length model.
module tb_key_debounce;

    localparam int unsigned N            = 2;
    localparam int unsigned TICK_BIT     = 2;
    localparam int unsigned STABLE_TICKS = 3;
    localparam int unsigned REPEAT_DELAY = 5;
    localparam int unsigned REPEAT_RATE  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  clk_div = 32'hFFFF_FF00;
    logic [N-1:0] key_in;
    logic [N-1:0] key_level, key_press, key_release, key_repeat;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    key_debounce #(
        .N            (N),
        .TICK_BIT     (TICK_BIT),
        .STABLE_TICKS (STABLE_TICKS),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div     (clk_div),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_div <= clk_div + 32'd1;

    // Reference model: a level flips once STABLE_TICKS consecutive samples disagree with it;
    // repeats fire at held-sample counts DELAY, DELAY+RATE, ... counted since the press.
    typedef struct {
        logic lvl;
        int   run;
        int   held;
        logic prs;
        logic rel;
        logic rpt;
    } mstate_t;

    mstate_t      m [N];
    logic [N-1:0] m_sync1, m_s;
    logic         m_prev;
    logic         m_tick;

    assign m_tick = clk_div[TICK_BIT] & ~m_prev;

    function automatic mstate_t model_step(mstate_t cur, logic tk, logic smp);
        mstate_t n = cur;
        n.prs = 1'b0;
        n.rel = 1'b0;
        n.rpt = 1'b0;
        if (tk) begin
            if (smp != cur.lvl) begin
                n.run = cur.run + 1;
                if (n.run == int'(STABLE_TICKS)) begin
                    n.lvl  = smp;
                    n.run  = 0;
                    n.held = 0;
                    n.prs  = smp;
                    n.rel  = ~smp;
                end
            end else if (cur.run > 0) begin
                n.run = 0;
            end else if (cur.lvl) begin
                n.held = cur.held + 1;
                if (REPEAT_DELAY > 0 && n.held >= int'(REPEAT_DELAY) &&
                    ((n.held - int'(REPEAT_DELAY)) % int'(REPEAT_RATE)) == 0)
                    n.rpt = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sync1 <= '0;
            m_s     <= '0;
            m_prev  <= 1'b0;
            for (int k = 0; k < int'(N); k++) m[k] <= '{default: 0};
        end else begin
            m_sync1 <= key_in;
            m_s     <= m_sync1;
            m_prev  <= clk_div[TICK_BIT];
            for (int k = 0; k < int'(N); k++) m[k] <= model_step(m[k], m_tick, m_s[k]);
        end
    end

    function automatic logic [4*N-1:0] model_out();
        logic [N-1:0] l, p, r, t;
        for (int k = 0; k < int'(N); k++) begin
            l[k] = m[k].lvl;
            p[k] = m[k].prs;
            r[k] = m[k].rel;
            t[k] = m[k].rpt;
        end
        return {l, p, r, t};
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({key_level, key_press, key_release, key_repeat} !== model_out()) begin
                miscompares++;
                $display("FAIL model t=%0t got lvl/prs/rel/rpt=%b expected %b", $time,
                         {key_level, key_press, key_release, key_repeat}, model_out());
            end
        end
    end

    typedef struct {
        string      name;
        logic [1:0] keys;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic [1:0] rpt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [1:0] k, input logic [1:0] l,
                       input logic [1:0] p, input logic [1:0] r, input logic [1:0] t);
        vec_t v;
        v.name = nm; v.keys = k; v.lvl = l; v.prs = p; v.rel = r; v.rpt = t;
        tbl.push_back(v);
    endtask

    task automatic check_vec(input string nm, input logic [1:0] l, input logic [1:0] p,
                             input logic [1:0] r, input logic [1:0] t);
        vectors++;
        if ({key_level, key_press, key_release, key_repeat} !== {l, p, r, t}) begin
            miscompares++;
            $display("FAIL %s got lvl=%b prs=%b rel=%b rpt=%b expected lvl=%b prs=%b rel=%b rpt=%b",
                     nm, key_level, key_press, key_release, key_repeat, l, p, r, t);
        end
    endtask

    // Drive keys, wait for the next tick cycle, leave sampling point in the following cycle
    task automatic step(input logic [1:0] keys);
        int n = 0;
        key_in = keys;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tick && n < 32);
        if (!m_tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout got no tick in %0d clk expected one within 8", n);
        end
        @(negedge clk);
    endtask

    // Release reset just after a tick-bit rise so synchronisers settle before the next tick
    task automatic release_reset();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_div[2:0] != 3'd5 && n < 32);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 2'b11;

        add("rst_t1",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add("rst_t2",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add("rst_press", 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        add("rel_t1",    2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add("rel_t2",    2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        add("rel_both",  2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        add("bnc_1",     2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("bnc_0",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add("bnc_1b",    2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("bnc_1c",    2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("bnc_press", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add("hold_1",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("hold_2",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("hold_3",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("hold_4",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("rpt_5",     2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add("hold_6",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("rpt_7",     2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add("rbnc_0",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add("rbnc_1",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("hold_8",    2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("rpt_9",     2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add("swap_a1",   2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add("swap_a2",   2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
        add("swap_a3",   2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
        add("swap_b1",   2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
        add("swap_b2",   2'b01, 2'b10, 2'b00, 2'b00, 2'b00);
        add("swap_b3",   2'b01, 2'b01, 2'b01, 2'b10, 2'b00);
        add("post_t1",   2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("post_t2",   2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        add("post_prs",  2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
        add("post_h1",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("post_h2",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("post_h3",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("post_h4",   2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        add("post_rpt",  2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        add("end_r1",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add("end_r2",    2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        add("end_rel",   2'b00, 2'b00, 2'b00, 2'b01, 2'b00);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_vec("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        release_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 28) begin
                // Reset while key0 is held: immediate clear, no release, then a fresh press
                rst = 1'b1;
                @(negedge clk);
                check_vec("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00);
                @(negedge clk);
                check_vec("rst_mid2", 2'b00, 2'b00, 2'b00, 2'b00);
                release_reset();
            end
            step(tbl[i].keys);
            check_vec(tbl[i].name, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt);
        end

        // Randomized segments, including sub-tick glitches and occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            key_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) rst = 1'b1;
            repeat ($urandom_range(1, 30)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
